// File: rtl/main_memory_refill.sv
// Main memory (1024 x 32) with a 4-beat block-refill responder and single-word write-through.
// Define MAIN_MEM_CRITICAL_WORD_EN for critical-word-first beat ordering.
module main_memory_refill #(
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        refill_valid,
  output logic [31:0] refill_data,
  output logic [9:0]  refill_addr,
  output logic        done
);

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;

  state_t            state;
  logic [31:0]       mem [0:1023];
  logic [CNT_W-1:0]  lat_cnt;
  logic [1:0]        beat;
  logic [9:0]        addr;
  logic [31:0]       wdata;
  logic [1:0]        beat_idx;
  logic [9:0]        beat_addr;
  logic              wr_fire;

  // The beat index only ever touches the low two bits, so a burst stays inside its block.
  always_comb begin
    beat_idx = beat;
`ifdef MAIN_MEM_CRITICAL_WORD_EN
    beat_idx = addr[1:0] + beat;
`else
    beat_idx = beat;
`endif
    beat_addr = {addr[9:2], beat_idx};
  end

  assign wr_fire = (state == WR_WAIT) && (lat_cnt == '0) && !rst;

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[addr] <= wdata;
  end

  // Beat 0 is emitted on the edge that leaves RD_WAIT; the final beat's edge already returns to
  // IDLE so a waiting request can be accepted right after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      refill_valid <= 1'b0;
      refill_data  <= '0;
      refill_addr  <= '0;
      done         <= 1'b0;
      lat_cnt      <= '0;
      beat         <= '0;
      addr         <= '0;
      wdata        <= '0;
    end else begin
      done         <= 1'b0;
      refill_valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (req_read) begin
            addr    <= req_addr;
            lat_cnt <= CNT_W'(READ_LATENCY - 1);
            beat    <= '0;
            busy    <= 1'b1;
            state   <= RD_WAIT;
          end else if (req_write) begin
            addr    <= req_addr;
            wdata   <= req_wdata;
            lat_cnt <= CNT_W'(WRITE_LATENCY - 1);
            busy    <= 1'b1;
            state   <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            refill_valid <= 1'b1;
            refill_addr  <= beat_addr;
            refill_data  <= mem[beat_addr];
            beat         <= beat + 2'd1;
            state        <= RD_BURST;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RD_BURST: begin
          refill_valid <= 1'b1;
          refill_addr  <= beat_addr;
          refill_data  <= mem[beat_addr];
          beat         <= beat + 2'd1;
          if (beat == 2'd3) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        WR_WAIT: begin
          if (lat_cnt == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_refill.sv
// Scoreboard bench for main_memory_refill: read bursts are predicted from a shadow memory.
module tb_main_memory_refill;

  localparam int RL = 4;
  localparam int WL = 4;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic        dn;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        busy, refill_valid, done;
  logic [31:0] refill_data;
  logic [9:0]  refill_addr;

  logic [31:0] model_mem [0:1023];
  beat_t       exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          busy_cycles, done_at, first_beat, done_cnt;

  main_memory_refill #(.READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
    .refill_valid(refill_valid), .refill_data(refill_data),
    .refill_addr(refill_addr), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every refill beat must match the oldest prediction.
  always @(negedge clk) begin
    if (refill_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("extra_beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        checkOutput("beat_addr", {22'd0, refill_addr}, {22'd0, e.a});
        checkOutput("beat_data", refill_data, e.d);
        checkOutput("beat_done", {31'd0, done}, {31'd0, e.dn});
      end
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [9:0] a,
                               input logic [31:0] d);
    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = a; req_wdata = d;
    if (rd) begin
      for (int k = 0; k < 4; k++) begin
        beat_t e;
        logic [1:0] idx;
`ifdef MAIN_MEM_CRITICAL_WORD_EN
        idx = a[1:0] + 2'(k);
`else
        idx = 2'(k);
`endif
        e.a  = {a[9:2], idx};
        e.d  = model_mem[e.a];
        e.dn = (k == 3);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    req_read = 1'b0; req_write = 1'b0;
  endtask

  task automatic waitIdle();
    busy_cycles = 0; done_at = 0; first_beat = 0; done_cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (refill_valid && first_beat == 0) first_beat = n;
      if (!busy) return;
    end
    checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic doWrite(input logic [9:0] a, input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, a, d);
    waitIdle();
    model_mem[a] = d;
  endtask

  task automatic doRead(input logic [9:0] a);
    applyStimulus(1'b1, 1'b0, a, 32'd0);
    waitIdle();
    checkOutput("read_done_cnt", done_cnt, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'hx;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, refill_valid}, 32'd0);
    checkOutput("rst_data", refill_data, 32'd0);
    checkOutput("rst_addr", {22'd0, refill_addr}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // Single write and its timing
    applyStimulus(1'b0, 1'b1, 10'h005, 32'hDEADBEEF);
    waitIdle();
    model_mem[10'h005] = 32'hDEADBEEF;
    checkOutput("wr_busy_cycles", busy_cycles, WL + 1);
    checkOutput("wr_done_at", done_at, WL + 1);
    checkOutput("wr_done_cnt", done_cnt, 32'd1);

    doWrite(10'h004, 32'h11);
    doWrite(10'h006, 32'h22);
    doWrite(10'h007, 32'h33);
    doRead(10'h004);

    for (int i = 0; i < 4; i++) doWrite(10'(4 + i), 32'hA0 + i);
    applyStimulus(1'b1, 1'b0, 10'h006, 32'd0);
    waitIdle();
    checkOutput("rd_first_beat", first_beat, RL + 1);
    checkOutput("rd_done_at", done_at, RL + 4);
    checkOutput("rd_busy_cycles", busy_cycles, RL + 4);
    checkOutput("rd_done_cnt", done_cnt, 32'd1);

    // Top-of-memory block must not wrap into word 0
    doWrite(10'h000, 32'h0BAD0000);
    for (int i = 0; i < 4; i++) doWrite(10'(10'h3FC + i), 32'hF0 + i);
    doRead(10'h3FE);

    // Simultaneous read and write: read wins, write is dropped
    for (int i = 0; i < 4; i++) doWrite(10'(10'h010 + i), 32'h50 + i);
    applyStimulus(1'b1, 1'b1, 10'h012, 32'h12345678);
    waitIdle();
    checkOutput("both_done_cnt", done_cnt, 32'd1);
    doRead(10'h010);

    // Write raised while busy is ignored
    applyStimulus(1'b1, 1'b0, 10'h004, 32'd0);
    @(negedge clk);
    checkOutput("busy_during_read", {31'd0, busy}, 32'd1);
    req_write = 1'b1; req_addr = 10'h005; req_wdata = 32'h0000BAD5;
    repeat (2) @(negedge clk);
    req_write = 1'b0;
    waitIdle();
    doRead(10'h004);

    // Reset after two delivered beats
    applyStimulus(1'b1, 1'b0, 10'h004, 32'd0);
    seen = 0;
    for (int n = 0; n < 40 && seen < 2; n++) begin
      @(negedge clk);
      if (refill_valid) seen++;
    end
    checkOutput("beats_before_rst", seen, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", {31'd0, refill_valid}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    doRead(10'h006);

    // Reset during WR_WAIT discards the write
    for (int i = 0; i < 4; i++) doWrite(10'(10'h020 + i), 32'h70 + i);
    applyStimulus(1'b0, 1'b1, 10'h021, 32'hCAFE0021);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("wrrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    doRead(10'h020);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_memory_refill.md
# main_memory_refill

Backing-store main memory with a block-refill responder for the direct-mapped data cache. It holds 1024 × 32-bit words and serves two request types from the cache controller. A read miss returns the full 4-word block as a burst on the cache refill port (`refill_data` drives the cache's refill data, `refill_valid` drives its move-to-cache strobe). A write-through request stores a single word. Each request completes after a fixed, parameterised access latency, and only one request is outstanding at a time.

## Interface
Parameters:
- `READ_LATENCY`, 4 — cycles from read acceptance to the first refill beat; must be ≥1.
- `WRITE_LATENCY`, 4 — cycles from write acceptance to the memory update; must be ≥1.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `req_read`  in  1  — block refill request; sampled only in IDLE.
- `req_write`  in  1  — single-word write request; sampled only in IDLE.
- `req_addr`  in  10  — word address; [9:2] selects the block, [1:0] the word within it.
- `req_wdata`  in  32  — write data.
- `busy`  out  1  — request in progress; new requests are ignored while high.
- `refill_valid`  out  1  — one beat of refill data is valid this cycle.
- `refill_data`  out  32  — refill word.
- `refill_addr`  out  10  — word address of the current beat.
- `done`  out  1  — one-cycle pulse marking request completion.

## Operation
- Storage: `mem[0:1023]`, 32-bit words. Contents are not affected by `rst`.
- All outputs are registered. Reset values: `busy`=0, `refill_valid`=0, `refill_data`=0, `refill_addr`=0, `done`=0, state=IDLE, counters=0.
- States: IDLE, RD_WAIT, RD_BURST, WR_WAIT.
- **IDLE**
  - If `req_read`=1: latch `req_addr`, load the latency counter, go to RD_WAIT.
  - Else if `req_write`=1: latch address and data, go to WR_WAIT.
  - If both are high, the read wins and the write is dropped; it is not queued.
- **RD_WAIT**
  - Count down `READ_LATENCY` cycles.
  - Then go to RD_BURST with beat counter = 0.
- **RD_BURST**
  - Four consecutive beats; `refill_valid`=1 on each beat with no gaps.
  - Beat k presents `refill_addr = {blk, idx_k}` and `refill_data = mem[refill_addr]`.
  - `done`=1 together with beat 3.
  - Then return to IDLE.
- **WR_WAIT**
  - Count down `WRITE_LATENCY` cycles.
  - Then write `mem[addr] <= wdata`, pulse `done`, and return to IDLE.
- Beat order (default): `idx_k = k`, i.e. 0,1,2,3. This matches the cache's internal 2-bit move counter.
- The beat counter is 2 bits and wraps modulo 4. The block never crosses into the neighbouring block, including at 0x3FC–0x3FF.
- Requests arriving while `busy`=1 are ignored, not buffered. The controller must hold a request until it sees `busy`=0.
- Reset mid-operation:
  - The FSM aborts to IDLE on the next edge and every output returns to its reset value.
  - A write still in WR_WAIT is discarded and memory is unchanged.
  - Beats already delivered stand.

## Timing
- Let E0 be the edge at which a request is accepted. `busy`=1 from the cycle after E0.
- Read:
  - Beats are visible in the cycles following edges E0+L, E0+L+1, E0+L+2, E0+L+3, where L=`READ_LATENCY`.
  - `done` coincides with the last beat.
  - `busy` and `refill_valid` fall after edge E0+L+4.
  - The earliest next acceptance is edge E0+L+4 if a request is waiting in IDLE.
- Write:
  - Memory is updated at edge E0+W, where W=`WRITE_LATENCY`.
  - `done` is high in the cycle after E0+W, with `busy` still 1.
  - `busy` falls after edge E0+W+1.
- `busy` always deasserts in the cycle after `done`.
- `refill_data` is registered from the array, so a beat's data is valid in the same cycle as its `refill_valid`.

## Configuration
- `MAIN_MEM_CRITICAL_WORD_EN`:
  - Defined: critical-word-first ordering, `idx_k = (req_addr[1:0] + k) mod 4`. The cache must place each beat using `refill_addr[1:0]`.
  - Undefined: sequential order 0..3 regardless of `req_addr[1:0]`.
  - Latency, beat count and `done` placement are identical in both builds.

## Test plan
- Write 0xDEADBEEF to 0x005 with W=4 → `busy` high for 5 cycles, `done` pulse 5 cycles after acceptance; a later read of block 0x004 returns 0xDEADBEEF on beat 1.
- Preload 0x004–0x007 with 0xA0..0xA3, then read at 0x006 with L=4 → beats begin 5 cycles after acceptance; `refill_addr` 0x004,0x005,0x006,0x007 with data 0xA0..0xA3, `done` on beat 3. With the macro defined: 0x006,0x007,0x004,0x005 carrying 0xA2,0xA3,0xA0,0xA1.
- Read at 0x3FE → all four beats stay within 0x3FC–0x3FF and no beat addresses 0x000.
- Assert `req_read` and `req_write` in the same IDLE cycle → the read burst is served, memory at the write address is unchanged, and exactly one `done` pulse occurs.
- Raise `req_write` while `busy`=1 during a read → it is ignored and memory is unchanged.
- Assert `rst` after 2 refill beats → next cycle `refill_valid`=0, `busy`=0, `done`=0; memory contents are intact and a fresh read succeeds.
